// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// Build option DMEM_ARB_RR_EN selects round-robin arbitration (see dmem_arb_pick).
package dmem_port_arbiter_pkg;

  typedef enum logic {LW = 1'b0, SW = 1'b1} load_store_func_code;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, ERR} dmem_arb_state_t;

  typedef enum logic {OWN_IF, OWN_LSU} dmem_owner_t;

  localparam logic [3:0] DMEM_BE_WORD = 4'hF;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Fetch, LSU and memory handshake bundle around the data-memory port arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface dmem_port_arbiter_if;
  import dmem_port_arbiter_pkg::*;

  logic                if_req_ip;
  logic [31:0]         if_addr_ip;
  logic                if_gnt_op;
  logic                if_rvalid_op;
  logic [31:0]         if_rdata_op;

  logic                lsu_req_ip;
  load_store_func_code lsu_operator_ip;
  logic [31:0]         lsu_addr_ip;
  logic [31:0]         lsu_wdata_ip;
  logic                lsu_gnt_op;
  logic                lsu_rvalid_op;
  logic [31:0]         lsu_rdata_op;
  logic                lsu_err_op;

  logic                mem_req_op;
  logic [31:0]         mem_addr_op;
  logic                mem_we_op;
  logic [3:0]          mem_be_op;
  logic [31:0]         mem_wdata_op;
  logic                mem_gnt_ip;
  logic                mem_rvalid_ip;
  logic [31:0]         mem_rdata_ip;

  modport slave (
    input  if_req_ip, if_addr_ip,
    output if_gnt_op, if_rvalid_op, if_rdata_op,
    input  lsu_req_ip, lsu_operator_ip, lsu_addr_ip, lsu_wdata_ip,
    output lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op, lsu_err_op,
    output mem_req_op, mem_addr_op, mem_we_op, mem_be_op, mem_wdata_op,
    input  mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip
  );

  modport master (
    output if_req_ip, if_addr_ip,
    input  if_gnt_op, if_rvalid_op, if_rdata_op,
    output lsu_req_ip, lsu_operator_ip, lsu_addr_ip, lsu_wdata_ip,
    input  lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op, lsu_err_op,
    input  mem_req_op, mem_addr_op, mem_we_op, mem_be_op, mem_wdata_op,
    output mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip
  );

endinterface

// File: rtl/dmem_port_arbiter_pick.sv
// Combinational requester selector: fixed LSU-over-IF priority, or round-robin
// on contention when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick
  import dmem_port_arbiter_pkg::*;
(
  input  logic        if_req,
  input  logic        lsu_req,
  input  dmem_owner_t last_owner,
  output logic        valid,
  output dmem_owner_t owner
);

  assign valid = if_req | lsu_req;

`ifdef DMEM_ARB_RR_EN
  // On contention the side that did not win last time goes next.
  always_comb begin
    owner = OWN_IF;
    if (lsu_req && (!if_req || last_owner == OWN_IF)) owner = OWN_LSU;
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    owner = lsu_req ? OWN_LSU : OWN_IF;
  end
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between fetch and LSU, one transaction in flight.
// Build option DMEM_ARB_RR_EN enables round-robin arbitration with a last_owner register.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  dmem_arb_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_owner_t      owner_q, owner_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;

  dmem_owner_t      last_owner_w;
  logic             pick_vld, pick_go;
  dmem_owner_t      pick_own;

  logic             if_gnt, lsu_gnt;
  logic             rsp_vld, rsp_err;
  logic [31:0]      rsp_data;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_be;

`ifdef DMEM_ARB_RR_EN
  dmem_owner_t last_owner_q, last_owner_d;
  assign last_owner_w = last_owner_q;
`else
  assign last_owner_w = OWN_IF;
`endif

  dmem_arb_pick u_pick (
    .if_req     (bus.if_req_ip),
    .lsu_req    (bus.lsu_req_ip),
    .last_owner (last_owner_w),
    .valid      (pick_vld),
    .owner      (pick_own)
  );

  // Grants are combinational, so hold them off while reset is asserted.
  assign pick_go = pick_vld & reset;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
`ifdef DMEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    if_gnt    = 1'b0;
    lsu_gnt   = 1'b0;
    rsp_vld   = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (pick_go) begin
          owner_d = pick_own;
`ifdef DMEM_ARB_RR_EN
          last_owner_d = pick_own;
`endif
          if (pick_own == OWN_LSU) begin
            lsu_gnt = 1'b1;
            addr_d  = bus.lsu_addr_ip;
            we_d    = (bus.lsu_operator_ip == SW);
            wdata_d = bus.lsu_wdata_ip;
            state_d = (bus.lsu_addr_ip[1:0] != 2'b00) ? ERR : REQ;
          end else begin
            if_gnt  = 1'b1;
            addr_d  = bus.if_addr_ip;
            we_d    = 1'b0;
            wdata_d = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_addr  = addr_q;
        mem_we    = we_q;
        mem_be    = DMEM_BE_WORD;
        mem_wdata = wdata_q;
        if (bus.mem_gnt_ip) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response arriving on the timeout cycle still counts as a response.
        if (bus.mem_rvalid_ip) begin
          rsp_vld  = 1'b1;
          rsp_data = we_q ? 32'h0 : bus.mem_rdata_ip;
          state_d  = IDLE;
        end else if (cnt_q == TMO) begin
          rsp_vld  = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        rsp_vld = 1'b1;
        rsp_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
`ifdef DMEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign bus.if_gnt_op     = if_gnt;
  assign bus.lsu_gnt_op    = lsu_gnt;
  assign bus.if_rvalid_op  = rsp_vld & (owner_q == OWN_IF);
  assign bus.if_rdata_op   = (owner_q == OWN_IF) ? rsp_data : 32'h0;
  assign bus.lsu_rvalid_op = rsp_vld & (owner_q == OWN_LSU);
  assign bus.lsu_rdata_op  = (owner_q == OWN_LSU) ? rsp_data : 32'h0;
  assign bus.lsu_err_op    = rsp_err & (owner_q == OWN_LSU);
  assign bus.mem_req_op    = mem_req;
  assign bus.mem_addr_op   = mem_addr;
  assign bus.mem_we_op     = mem_we;
  assign bus.mem_be_op     = mem_be;
  assign bus.mem_wdata_op  = mem_wdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration, latency and responses.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int TMO = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_port_arbiter_if bus();

  dmem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // memory environment state
  int          gnt_dly   = 0;
  int          rsp_dly   = 0;
  int          gwait     = 0;
  int          rsp_cnt   = -1;
  bit          rsp_never = 1'b0;
  bit          force_rv  = 1'b0;
  logic [31:0] rsp_word  = 32'h0;

  // arbitration model: did the LSU win the last grant
  bit model_last_lsu = 1'b0;

  function automatic bit model_pick_lsu(input bit ifr, input bit lsur);
    bit w;
`ifdef DMEM_ARB_RR_EN
    if (ifr && lsur) w = !model_last_lsu;
    else             w = lsur;
`else
    w = lsur;
`endif
    model_last_lsu = w;
    return w;
  endfunction

  // Advance to just after the next rising edge and play the memory side.
  task automatic adv();
    @(posedge clock); #1;
    bus.mem_gnt_ip    = 1'b0;
    bus.mem_rvalid_ip = 1'b0;
    bus.mem_rdata_ip  = 32'h0;
    if (force_rv) begin
      bus.mem_rvalid_ip = 1'b1;
      bus.mem_rdata_ip  = 32'hBAD0_0BAD;
      force_rv = 1'b0;
    end else if (rsp_cnt == 0) begin
      bus.mem_rvalid_ip = 1'b1;
      bus.mem_rdata_ip  = rsp_word;
      rsp_cnt = -1;
    end else if (rsp_cnt > 0) begin
      rsp_cnt--;
    end else if (bus.mem_req_op) begin
      if (gwait == gnt_dly) begin
        bus.mem_gnt_ip = 1'b1;
        gwait   = 0;
        rsp_cnt = rsp_never ? -1 : rsp_dly;
      end else begin
        gwait++;
      end
    end
  endtask

  task automatic clear_inputs();
    bus.if_req_ip       = 1'b0;
    bus.if_addr_ip      = 32'h0;
    bus.lsu_req_ip      = 1'b0;
    bus.lsu_operator_ip = LW;
    bus.lsu_addr_ip     = 32'h0;
    bus.lsu_wdata_ip    = 32'h0;
    bus.mem_gnt_ip      = 1'b0;
    bus.mem_rvalid_ip   = 1'b0;
    bus.mem_rdata_ip    = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    gnt_dly = 0; rsp_dly = 0; gwait = 0; rsp_cnt = -1;
    rsp_never = 1'b0; force_rv = 1'b0; model_last_lsu = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic lsu_drive(input load_store_func_code op, input logic [31:0] a, input logic [31:0] d);
    bus.lsu_req_ip      = 1'b1;
    bus.lsu_operator_ip = op;
    bus.lsu_addr_ip     = a;
    bus.lsu_wdata_ip    = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.if_req_ip = 1'b1; bus.if_addr_ip = 32'h44;
    lsu_drive(SW, 32'h80, 32'h5555_AAAA);
    bus.mem_gnt_ip = 1'b1; bus.mem_rvalid_ip = 1'b1; bus.mem_rdata_ip = 32'hFFFF_FFFF;
    #2;
    checks++;
    if ({bus.if_gnt_op, bus.if_rvalid_op, bus.lsu_gnt_op, bus.lsu_rvalid_op, bus.lsu_err_op,
         bus.mem_req_op, bus.mem_we_op, bus.mem_be_op} !== 11'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {bus.if_gnt_op, bus.if_rvalid_op, bus.lsu_gnt_op,
               bus.lsu_rvalid_op, bus.lsu_err_op, bus.mem_req_op, bus.mem_we_op, bus.mem_be_op});
    end
    checks++;
    if ({bus.if_rdata_op, bus.lsu_rdata_op, bus.mem_addr_op, bus.mem_wdata_op} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want 0", bus.if_rdata_op, bus.lsu_rdata_op,
               bus.mem_addr_op, bus.mem_wdata_op);
    end
  endtask

  task automatic test_lw_basic();
    do_reset();
    rsp_word = 32'hDEAD_BEEF;
    adv(); lsu_drive(LW, 32'h100, 32'h0);
    @(negedge clock);
    checks++;
    if ({bus.lsu_gnt_op, bus.if_gnt_op, bus.mem_req_op} !== 3'b100) begin
      errors++; $display("FAIL lw_gnt: got %b want 100", {bus.lsu_gnt_op, bus.if_gnt_op, bus.mem_req_op});
    end
    adv(); bus.lsu_req_ip = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.mem_req_op, bus.mem_addr_op, bus.mem_we_op, bus.mem_be_op} !== {1'b1, 32'h100, 1'b0, 4'hF}) begin
      errors++; $display("FAIL lw_memreq: got req=%b addr=%h we=%b be=%h", bus.mem_req_op,
                         bus.mem_addr_op, bus.mem_we_op, bus.mem_be_op);
    end
    adv(); @(negedge clock);
    checks++;
    if ({bus.lsu_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op, bus.if_rvalid_op} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL lw_rsp: got rv=%b err=%b data=%h if_rv=%b want 1 0 deadbeef 0",
                         bus.lsu_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op, bus.if_rvalid_op);
    end
    adv(); @(negedge clock);
    checks++;
    if (bus.lsu_rvalid_op !== 1'b0) begin
      errors++; $display("FAIL lw_rv_pulse: got %b want 0", bus.lsu_rvalid_op);
    end
  endtask

  task automatic test_sw_misaligned();
    do_reset();
    adv(); lsu_drive(SW, 32'h102, 32'hCAFE_F00D);
    @(negedge clock);
    checks++;
    if ({bus.lsu_gnt_op, bus.mem_req_op} !== 2'b10) begin
      errors++; $display("FAIL mis_gnt: got %b want 10", {bus.lsu_gnt_op, bus.mem_req_op});
    end
    adv(); bus.lsu_req_ip = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.lsu_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op, bus.mem_req_op} !== {2'b11, 32'h0, 1'b0}) begin
      errors++; $display("FAIL mis_rsp: got rv=%b err=%b data=%h req=%b want 1 1 0 0",
                         bus.lsu_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op, bus.mem_req_op);
    end
    adv(); @(negedge clock);
    checks++;
    if ({bus.lsu_rvalid_op, bus.mem_req_op} !== 2'b00) begin
      errors++; $display("FAIL mis_after: got %b want 00", {bus.lsu_rvalid_op, bus.mem_req_op});
    end
  endtask

  task automatic test_contention();
    bit got[$];
    do_reset();
    rsp_word = 32'h1111_2222;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      adv();
      bus.if_req_ip = 1'b1; bus.if_addr_ip = 32'h40;
      lsu_drive(LW, 32'h80, 32'h0);
      @(negedge clock);
      if (bus.lsu_gnt_op || bus.if_gnt_op) got.push_back(bus.lsu_gnt_op);
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL cont_count: got %0d grants want 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      bit exp_lsu;
      exp_lsu = model_pick_lsu(1'b1, 1'b1);
      checks++;
      if (got[i] !== exp_lsu) begin
        errors++; $display("FAIL cont_order[%0d]: got lsu=%b want lsu=%b", i, got[i], exp_lsu);
      end
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    gnt_dly = 5; rsp_dly = 1; rsp_word = 32'h1234_5678;
    adv(); lsu_drive(LW, 32'h200, 32'h0);
    @(negedge clock);
    for (int k = 1; k <= 8; k++) begin
      adv(); bus.lsu_req_ip = 1'b0;
      @(negedge clock);
      if (k <= 6) begin
        checks++;
        if ({bus.mem_req_op, bus.mem_addr_op, bus.mem_we_op} !== {1'b1, 32'h200, 1'b0}) begin
          errors++; $display("FAIL stall_hold k=%0d: got req=%b addr=%h we=%b", k,
                             bus.mem_req_op, bus.mem_addr_op, bus.mem_we_op);
        end
      end else if (k == 7) begin
        checks++;
        if ({bus.mem_req_op, bus.lsu_rvalid_op} !== 2'b00) begin
          errors++; $display("FAIL stall_wait: got %b want 00", {bus.mem_req_op, bus.lsu_rvalid_op});
        end
      end else begin
        checks++;
        if ({bus.lsu_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op} !== {2'b10, 32'h1234_5678}) begin
          errors++; $display("FAIL stall_rsp: got rv=%b err=%b data=%h", bus.lsu_rvalid_op,
                             bus.lsu_err_op, bus.lsu_rdata_op);
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    rsp_never = 1'b1;
    adv(); lsu_drive(LW, 32'h300, 32'h0);
    @(negedge clock);
    for (int k = 1; k <= 8; k++) begin
      if (k == 7) force_rv = 1'b1;
      adv(); bus.lsu_req_ip = 1'b0;
      @(negedge clock);
      if (k == 2 + TMO) begin
        checks++;
        if ({bus.lsu_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op} !== {2'b11, 32'h0}) begin
          errors++; $display("FAIL tmo_rsp: got rv=%b err=%b data=%h want 1 1 0",
                             bus.lsu_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op);
        end
      end else if (k >= 2) begin
        checks++;
        if ({bus.lsu_rvalid_op, bus.if_rvalid_op, bus.mem_req_op} !== 3'b000) begin
          errors++; $display("FAIL tmo_quiet k=%0d: got %b want 000", k,
                             {bus.lsu_rvalid_op, bus.if_rvalid_op, bus.mem_req_op});
        end
      end
    end
    rsp_never = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_never = 1'b1;
    adv(); lsu_drive(LW, 32'h400, 32'h0);
    @(negedge clock);
    adv(); bus.lsu_req_ip = 1'b0;
    adv();
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.lsu_rvalid_op, bus.lsu_err_op, bus.if_rvalid_op, bus.mem_req_op, bus.mem_addr_op} !== 36'h0) begin
      errors++; $display("FAIL rst_mid: got rv=%b err=%b if_rv=%b req=%b addr=%h", bus.lsu_rvalid_op,
                         bus.lsu_err_op, bus.if_rvalid_op, bus.mem_req_op, bus.mem_addr_op);
    end
    @(posedge clock); #1 reset = 1'b1;
    rsp_never = 1'b0; rsp_dly = 0; rsp_word = 32'h0F0F_0F0F;
    force_rv = 1'b1;
    adv(); @(negedge clock);
    checks++;
    if ({bus.lsu_rvalid_op, bus.if_rvalid_op} !== 2'b00) begin
      errors++; $display("FAIL rst_stale: got %b want 00", {bus.lsu_rvalid_op, bus.if_rvalid_op});
    end
    adv(); lsu_drive(LW, 32'h500, 32'h0);
    @(negedge clock);
    checks++;
    if (bus.lsu_gnt_op !== 1'b1) begin
      errors++; $display("FAIL rst_regnt: got %b want 1", bus.lsu_gnt_op);
    end
    adv(); bus.lsu_req_ip = 1'b0;
    adv(); @(negedge clock);
    checks++;
    if ({bus.lsu_rvalid_op, bus.lsu_rdata_op} !== {1'b1, 32'h0F0F_0F0F}) begin
      errors++; $display("FAIL rst_after_rsp: got rv=%b data=%h", bus.lsu_rvalid_op, bus.lsu_rdata_op);
    end
  endtask

  task automatic test_random();
    bit if_p = 1'b0, lsu_p = 1'b0;
    logic [31:0] ia = 32'h0, la = 32'h0, lw = 32'h0;
    load_store_func_code lop = LW;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      bit win_lsu, mis, e_we, e_err;
      logic [31:0] e_addr, e_data;
      int resp_at;
      if (!if_p && $urandom_range(0, 2) != 0) begin if_p = 1'b1; ia = $urandom(); end
      if (!lsu_p && $urandom_range(0, 2) != 0) begin
        lsu_p = 1'b1;
        la = $urandom() & 32'h0000_FFFC;
        if ($urandom_range(0, 3) == 0) la[1:0] = 2'($urandom_range(1, 3));
        lop = ($urandom_range(0, 1) != 0) ? SW : LW;
        lw = $urandom();
      end
      if (!if_p && !lsu_p) begin if_p = 1'b1; ia = $urandom(); end
      gnt_dly = $urandom_range(0, 3);
      rsp_never = ($urandom_range(0, 3) == 0);
      rsp_dly = $urandom_range(0, TMO);
      rsp_word = $urandom();

      win_lsu = model_pick_lsu(if_p, lsu_p);
      mis     = win_lsu && (la[1:0] != 2'b00);
      e_we    = win_lsu && (lop == SW);
      e_addr  = win_lsu ? la : ia;
      resp_at = mis ? 1 : 2 + gnt_dly + (rsp_never ? TMO : rsp_dly);
      e_err   = mis || (rsp_never && win_lsu);
      e_data  = (mis || rsp_never || e_we) ? 32'h0 : rsp_word;

      adv();
      bus.if_req_ip = if_p; bus.if_addr_ip = ia;
      bus.lsu_req_ip = lsu_p; bus.lsu_operator_ip = lop; bus.lsu_addr_ip = la; bus.lsu_wdata_ip = lw;
      @(negedge clock);
      checks++;
      if ({bus.lsu_gnt_op, bus.if_gnt_op} !== {win_lsu, !win_lsu}) begin
        errors++; $display("FAIL rnd_gnt n=%0d: got %b want %b", n,
                           {bus.lsu_gnt_op, bus.if_gnt_op}, {win_lsu, !win_lsu});
      end
      if (win_lsu) lsu_p = 1'b0; else if_p = 1'b0;

      for (int k = 1; k <= resp_at; k++) begin
        adv();
        bus.if_req_ip = if_p; bus.lsu_req_ip = lsu_p;
        @(negedge clock);
        checks++;
        if ({bus.lsu_gnt_op, bus.if_gnt_op} !== 2'b00) begin
          errors++; $display("FAIL rnd_busy_gnt n=%0d k=%0d: got %b want 00", n, k,
                             {bus.lsu_gnt_op, bus.if_gnt_op});
        end
        if (k == 1 && mis) begin
          checks++;
          if (bus.mem_req_op !== 1'b0) begin
            errors++; $display("FAIL rnd_mis_req n=%0d: got %b want 0", n, bus.mem_req_op);
          end
        end else if (k == 1) begin
          checks++;
          if ({bus.mem_req_op, bus.mem_addr_op, bus.mem_we_op, bus.mem_be_op} !== {1'b1, e_addr, e_we, 4'hF} ||
              (e_we && bus.mem_wdata_op !== lw)) begin
            errors++; $display("FAIL rnd_memreq n=%0d: got req=%b addr=%h we=%b be=%h wd=%h want 1 %h %b f %h",
                               n, bus.mem_req_op, bus.mem_addr_op, bus.mem_we_op, bus.mem_be_op,
                               bus.mem_wdata_op, e_addr, e_we, lw);
          end
        end
        if (k < resp_at) begin
          checks++;
          if ({bus.lsu_rvalid_op, bus.if_rvalid_op} !== 2'b00) begin
            errors++; $display("FAIL rnd_early_rv n=%0d k=%0d: got %b want 00", n, k,
                               {bus.lsu_rvalid_op, bus.if_rvalid_op});
          end
        end else if (win_lsu) begin
          checks++;
          if ({bus.lsu_rvalid_op, bus.if_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op} !== {2'b10, e_err, e_data}) begin
            errors++; $display("FAIL rnd_lsu_rsp n=%0d: got rv=%b if_rv=%b err=%b data=%h want 1 0 %b %h",
                               n, bus.lsu_rvalid_op, bus.if_rvalid_op, bus.lsu_err_op, bus.lsu_rdata_op,
                               e_err, e_data);
          end
        end else begin
          checks++;
          if ({bus.lsu_rvalid_op, bus.if_rvalid_op, bus.if_rdata_op} !== {2'b01, e_data}) begin
            errors++; $display("FAIL rnd_if_rsp n=%0d: got lsu_rv=%b rv=%b data=%h want 0 1 %h",
                               n, bus.lsu_rvalid_op, bus.if_rvalid_op, bus.if_rdata_op, e_data);
          end
        end
      end
    end
    rsp_never = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_lw_basic();
    test_sw_misaligned();
    test_contention();
    test_gnt_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
